// File: rtl/vector_segment_drawer.sv
// Beam-path engine for an XY vector display: walks the X/Y DAC codes to each
// commanded target with Bresenham stepping, blanked jumps with settle time.
`timescale 1ns/1ps
module vector_segment_drawer #(
    parameter int unsigned CH_WIDTH = 8,
    parameter int unsigned STEP_DIV = 4,
    parameter int unsigned SETTLE   = 16,
    parameter int unsigned DWELL    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CH_WIDTH-1:0] cmd_x,
    input  logic [CH_WIDTH-1:0] cmd_y,
    input  logic                cmd_draw,
    output logic [CH_WIDTH-1:0] x_ch,
    output logic [CH_WIDTH-1:0] y_ch,
    output logic                beam,
    output logic                busy,
    output logic                seg_done
);

    localparam int unsigned CntMax = (STEP_DIV > SETTLE)
        ? ((STEP_DIV > DWELL) ? STEP_DIV : DWELL)
        : ((SETTLE > DWELL) ? SETTLE : DWELL);
    localparam int unsigned CntW = $clog2(CntMax + 1);
    localparam int unsigned EW   = CH_WIDTH + 2;
    localparam int unsigned E2W  = CH_WIDTH + 3;

    typedef enum logic [1:0] {StIdle, StSettle, StDraw, StDwell} state_e;

    state_e                state_q, state_d;
    logic [CH_WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic [CH_WIDTH-1:0]   tx_q, tx_d, ty_q, ty_d;
    logic [CH_WIDTH-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic                  sx_q, sx_d, sy_q, sy_d;
    logic signed [EW-1:0]  err_q, err_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  beam_q, beam_d;
    logic                  seg_done_q, seg_done_d;

    // Bresenham terms for an incoming command, relative to the current beam
    logic [CH_WIDTH-1:0]   dx_new, dy_new;
    logic                  sx_new, sy_new;
    logic signed [EW-1:0]  err_new;

    always_comb begin
        sx_new  = (cmd_x < x_q);
        sy_new  = (cmd_y < y_q);
        dx_new  = sx_new ? (x_q - cmd_x) : (cmd_x - x_q);
        dy_new  = sy_new ? (y_q - cmd_y) : (cmd_y - y_q);
        err_new = $signed({2'b00, dx_new}) - $signed({2'b00, dy_new});
    end

    // One Bresenham step from the current position
    logic signed [E2W-1:0] e2, dx_s, dy_s, err_acc;
    logic                  step_x, step_y;
    logic [CH_WIDTH-1:0]   x_nxt, y_nxt;
    logic signed [EW-1:0]  err_step;

    always_comb begin
        e2      = {err_q, 1'b0};
        dx_s    = $signed({3'b000, dx_q});
        dy_s    = $signed({3'b000, dy_q});
        step_x  = (e2 > -dy_s);
        step_y  = (e2 < dx_s);
        err_acc = {err_q[EW-1], err_q};
        if (step_x) begin
            err_acc = err_acc - dy_s;
        end
        if (step_y) begin
            err_acc = err_acc + dx_s;
        end
        err_step = err_acc[EW-1:0];
        x_nxt    = x_q;
        y_nxt    = y_q;
        if (step_x) begin
            x_nxt = sx_q ? (x_q - CH_WIDTH'(1)) : (x_q + CH_WIDTH'(1));
        end
        if (step_y) begin
            y_nxt = sy_q ? (y_q - CH_WIDTH'(1)) : (y_q + CH_WIDTH'(1));
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        beam_d     = beam_q;
        // A completion pulse is never frozen by enable, so it lasts one cycle
        seg_done_d = 1'b0;
        cmd_ready  = enable && (state_q == StIdle);

        if (enable) begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        tx_d  = cmd_x;
                        ty_d  = cmd_y;
                        dx_d  = dx_new;
                        dy_d  = dy_new;
                        sx_d  = sx_new;
                        sy_d  = sy_new;
                        err_d = err_new;
                        cnt_d = '0;
                        if (cmd_draw) begin
                            beam_d  = 1'b1;
                            state_d = ((dx_new == '0) && (dy_new == '0)) ? StDwell : StDraw;
                        end else begin
                            x_d     = cmd_x;
                            y_d     = cmd_y;
                            beam_d  = 1'b0;
                            state_d = StSettle;
                        end
                    end
                end
                StSettle: begin
                    if (cnt_q == CntW'(SETTLE - 1)) begin
                        cnt_d      = '0;
                        state_d    = StIdle;
                        seg_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StDraw: begin
                    if (cnt_q == CntW'(STEP_DIV - 1)) begin
                        cnt_d = '0;
                        x_d   = x_nxt;
                        y_d   = y_nxt;
                        err_d = err_step;
                        if ((x_nxt == tx_q) && (y_nxt == ty_q)) begin
                            state_d = StDwell;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StDwell: begin
                    if (cnt_q == CntW'(DWELL - 1)) begin
                        cnt_d      = '0;
                        beam_d     = 1'b0;
                        state_d    = StIdle;
                        seg_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            tx_q       <= '0;
            ty_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            sx_q       <= 1'b0;
            sy_q       <= 1'b0;
            err_q      <= '0;
            cnt_q      <= '0;
            beam_q     <= 1'b0;
            seg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            beam_q     <= beam_d;
            seg_done_q <= seg_done_d;
        end
    end

    assign x_ch     = x_q;
    assign y_ch     = y_q;
    assign beam     = beam_q;
    assign busy     = (state_q != StIdle);
    assign seg_done = seg_done_q;

endmodule

// File: doc/vector_segment_drawer.md
# vector_segment_drawer

Parametrised beam-path engine for the XY vector display. It accepts one segment command at a time: a target point plus a draw/blank flag. It walks the X/Y DAC channel codes from the current beam position to the target using Bresenham stepping at a programmable step rate. Blanked moves jump directly to the target and then wait a settle time; drawn segments dwell at the endpoint. It sits between the display-list sequencer and the X/Y DAC output stages, running in the pixel-clock domain.

## Interface
Parameters:
- CH_WIDTH, 8, width of each channel code (x_ch, y_ch, cmd_x, cmd_y)
- STEP_DIV, 4, clock cycles per Bresenham step (>=1)
- SETTLE, 16, hold cycles after a blanked jump (>=1)
- DWELL, 2, hold cycles at the endpoint of a drawn segment (>=1)

Ports:
- clk  in  1  pixel clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- enable  in  1  1 = run; 0 = freeze all counters and position, cmd_ready low
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command this cycle
- cmd_x  in  CH_WIDTH  target X code
- cmd_y  in  CH_WIDTH  target Y code
- cmd_draw  in  1  1 = drawn segment (beam on), 0 = blanked move
- x_ch  out  CH_WIDTH  X DAC code, registered
- y_ch  out  CH_WIDTH  Y DAC code, registered
- beam  out  1  beam/Z enable, registered
- busy  out  1  state != IDLE
- seg_done  out  1  one-cycle pulse on completion of each command

## Operation
- Reset values: x_ch=0, y_ch=0, beam=0, busy=0, seg_done=0, state=IDLE, all counters 0.
- States: IDLE, SETTLE, DRAW, DWELL.
- IDLE:
  - cmd_ready = enable.
  - Accept on cmd_valid & cmd_ready, latching target, draw flag and Bresenham terms.
  - Terms: dx=|tx-x|, dy=|ty-y|, sx/sy=+/-1, err=dx-dy. err is signed, CH_WIDTH+2 bits.
- Blanked accept (cmd_draw=0):
  - Next cycle: x_ch=tx, y_ch=ty, beam=0, state SETTLE.
  - SETTLE counts SETTLE enabled cycles, then returns to IDLE.
- Drawn accept (cmd_draw=1):
  - Next cycle: beam=1.
  - If dx=dy=0 (dot), go straight to DWELL; otherwise go to DRAW.
- DRAW:
  - Step counter increments each enabled cycle.
  - At STEP_DIV-1 it wraps to 0 and performs one step with e2=2*err:
    - if e2 > -dy: err -= dy, x += sx
    - if e2 < dx: err += dx, y += sy
    - both may apply in the same step (diagonal move)
  - When the new position equals the target, go to DWELL.
  - Position never overshoots or wraps; codes stay within 0..2^CH_WIDTH-1.
- DWELL:
  - beam=1 for DWELL enabled cycles, then IDLE with beam=0.
- seg_done:
  - Asserted in the first IDLE cycle after SETTLE or DWELL completes.
  - cmd_ready is high in that same cycle, so back-to-back commands are legal.
- enable=0:
  - All state, counters, outputs and err are held.
  - cmd_ready=0; a pending seg_done still pulses exactly once.
- A reset mid-operation aborts the command immediately: outputs go to reset values and the command is dropped.

## Timing
- Accept at edge T. The first DRAW/SETTLE/DWELL cycle is T+1.
- Blanked move: new position visible at T+1; seg_done at T+1+SETTLE.
- Drawn segment with N=max(dx,dy) steps:
  - Step k (k=1..N) is visible at T+1+k*STEP_DIV.
  - seg_done at T+1+N*STEP_DIV+DWELL.
- Dot: seg_done at T+1+DWELL.
- No combinational path from cmd_* to any output except cmd_ready, which depends on state and enable only.

## Test plan
- Reset: hold rst=0 with random inputs -> x_ch=y_ch=0, beam=0, busy=0; after release with enable=1, cmd_ready=1 on the next cycle.
- Blank jump from (0,0) to (200,100), SETTLE=16 -> x_ch=200, y_ch=100, beam=0 at T+1; seg_done at T+17, single cycle.
- Horizontal draw (0,0)->(5,0), STEP_DIV=4, DWELL=2 -> x_ch=1..5 at T+5, T+9, T+13, T+17, T+21; beam=1 from T+1 through T+22; seg_done at T+23.
- Steep draw (0,0)->(2,5) -> position sequence (0,1), (1,2), (1,3), (2,4), (2,5); then reverse (255,255)->(250,255) -> x decrements 254..250 with no wrap; then dot at (7,7) -> seg_done at T+1+DWELL with no position change.
- Freeze: drop enable for 10 cycles mid-draw -> outputs and step phase held; completion delayed exactly 10 cycles; cmd_ready=0 throughout.
- Async reset during DRAW, asserted between clock edges -> outputs reach reset values immediately; the next command starts from (0,0).
